router_reg: RTL and testbench
=============================

Name: router_reg

Overview:
- Datapath register stage directly downstream of router_fsm in the 1x3 packet router.
- Consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and the incoming byte stream.
- Produces the byte written into the selected output FIFO (dout), plus the parity_done, low_packet_valid and err status bits that router_fsm and the top level consume.
- Packet format: header byte (bits[7:2] = payload length, bits[1:0] = destination address; 2'b11 is reserved), then payload bytes, then one parity byte (XOR of header and all payload bytes).

Parameters:
- WIDTH, 8, byte width of data_in/dout. Address field is always bits [1:0].

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- pkt_valid  input  1  high while header/payload bytes are on data_in; low on the parity byte.
- data_in  input  WIDTH  incoming byte.
- fifo_full  input  1  selected destination FIFO is full.
- detect_add  input  1  FSM DECODE_ADDRESS state.
- lfd_state  input  1  FSM LOAD_FIRST_DATA state.
- ld_state  input  1  FSM LOAD_DATA state.
- laf_state  input  1  FSM LOAD_AFTER_FULL state.
- full_state  input  1  FSM FIFO_FULL_STATE; no byte is captured or accumulated.
- rst_int_reg  input  1  FSM CHECK_PARITY_ERROR strobe; clears low_packet_valid.
- dout  output  WIDTH  byte to the FIFO write port.
- parity_done  output  1  parity byte has been captured.
- low_packet_valid  output  1  pkt_valid fell during ld_state.
- err  output  1  parity mismatch for the last packet.

Behaviour:
- One clock; reset is asynchronous and active-high. While reset=1, all outputs and internal registers are 0: dout, parity_done, low_packet_valid, err, header_reg, hold_reg, hold_is_parity, int_parity, pkt_parity.
- All outputs are registered. Each effect lands on the rising edge at the end of the cycle in which its strobe is sampled (1-cycle latency).
- Strobe priority when more than one is high (illegal from the FSM, but defined): detect_add > lfd_state > ld_state > laf_state > full_state.
- detect_add:
  - If pkt_valid=1 and data_in[1:0]!=2'b11: header_reg<=data_in.
  - Otherwise header_reg is unchanged.
  - Always clears int_parity, pkt_parity, parity_done, err, low_packet_valid.
  - dout is unchanged.
- lfd_state: dout<=header_reg; int_parity<=int_parity^header_reg.
- ld_state with fifo_full=0:
  - dout<=data_in.
  - If pkt_valid=1: int_parity^=data_in.
  - If pkt_valid=0: pkt_parity<=data_in, parity_done<=1.
- ld_state with fifo_full=1:
  - dout is unchanged.
  - hold_reg<=data_in; hold_is_parity<=~pkt_valid.
  - No parity update.
- ld_state with pkt_valid=0 (regardless of fifo_full): low_packet_valid<=1.
- laf_state:
  - dout<=hold_reg.
  - If hold_is_parity=1: pkt_parity<=hold_reg, parity_done<=1.
  - Else: int_parity^=hold_reg.
  - A second laf cycle with parity_done=1 re-drives dout and changes nothing else.
- full_state: all registers hold.
- rst_int_reg: low_packet_valid<=0. Lower priority than a simultaneous ld_state set.
- err: on the edge after parity_done is first seen high, err<=(int_parity!=pkt_parity). It then holds until detect_add or reset.
- parity_done stays high until the next detect_add, so back-to-back packets must pass through DECODE.
- Reset mid-packet clears everything immediately. The next packet starts clean with no residual parity.

Test Plan:
- Reset: assert reset mid-cycle with a packet in flight -> all outputs read 0 asynchronously, before the next clock edge.
- Good packet: header 8'h0C, then 8'hA5, 8'h3C, 8'h0F, then parity 8'h9A, fifo_full=0 ->
  - dout sequence 0C, A5, 3C, 0F, 9A, one cycle after each strobe.
  - parity_done=1 after the parity byte; low_packet_valid=1.
  - err=0 one cycle later.
- Bad parity: same packet with parity 8'h00 -> err=1 one cycle after parity_done; err clears on the next detect_add.
- FIFO full mid-payload: fifo_full=1 during ld_state with data 8'h3C, then full_state 2 cycles, then laf_state ->
  - dout stays at A5 during full.
  - dout=3C on the laf edge; final err=0.
- FIFO full on the parity byte: fifo_full=1 when 8'h9A is presented with pkt_valid=0 ->
  - parity_done stays 0 until laf_state, then parity_done=1 and dout=9A.
  - low_packet_valid=1 immediately.
- Reserved address: detect_add with data_in=8'h0F -> header_reg keeps its prior value (8'h0C); a following lfd_state drives dout=0C. Also check rst_int_reg clears low_packet_valid.

Source files
------------

// File: rtl/router_reg.sv
// Router datapath register stage: latches the header, forwards bytes to the FIFO,
// buffers a byte across FIFO-full stalls and checks packet parity.
module router_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fifo_full,
  input  logic             detect_add,
  input  logic             lfd_state,
  input  logic             ld_state,
  input  logic             laf_state,
  input  logic             full_state,
  input  logic             rst_int_reg,
  output logic [WIDTH-1:0] dout,
  output logic             parity_done,
  output logic             low_packet_valid,
  output logic             err
);

  logic [WIDTH-1:0] header_reg;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_is_parity;
  logic [WIDTH-1:0] int_parity;
  logic [WIDTH-1:0] pkt_parity;
  logic             err_checked;
  logic             ld_active;
  logic             laf_active;

  // Strobe priority: detect_add > lfd_state > ld_state > laf_state > full_state.
  assign ld_active  = ld_state && !detect_add && !lfd_state;
  assign laf_active = laf_state && !detect_add && !lfd_state && !ld_state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout             <= '0;
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
      err              <= 1'b0;
      header_reg       <= '0;
      hold_reg         <= '0;
      hold_is_parity   <= 1'b0;
      int_parity       <= '0;
      pkt_parity       <= '0;
      err_checked      <= 1'b0;
    end else begin
      if (detect_add) begin
        if (pkt_valid && data_in[1:0] != 2'b11) header_reg <= data_in;
        int_parity  <= '0;
        pkt_parity  <= '0;
        parity_done <= 1'b0;
      end else if (lfd_state) begin
        dout       <= header_reg;
        int_parity <= int_parity ^ header_reg;
      end else if (ld_active) begin
        if (!fifo_full) begin
          dout <= data_in;
          if (pkt_valid) begin
            int_parity <= int_parity ^ data_in;
          end else begin
            pkt_parity  <= data_in;
            parity_done <= 1'b1;
          end
        end else begin
          // FIFO stalled: park the byte until LOAD_AFTER_FULL replays it.
          hold_reg       <= data_in;
          hold_is_parity <= ~pkt_valid;
        end
      end else if (laf_active) begin
        dout <= hold_reg;
        if (!parity_done) begin
          if (hold_is_parity) begin
            pkt_parity  <= hold_reg;
            parity_done <= 1'b1;
          end else begin
            int_parity <= int_parity ^ hold_reg;
          end
        end
      end

      if (detect_add) begin
        low_packet_valid <= 1'b0;
      end else if (ld_active && !pkt_valid) begin
        low_packet_valid <= 1'b1;
      end else if (rst_int_reg) begin
        low_packet_valid <= 1'b0;
      end

      // Parity is compared once, on the first cycle parity_done is visible.
      if (detect_add) begin
        err         <= 1'b0;
        err_checked <= 1'b0;
      end else if (parity_done && !err_checked) begin
        err         <= (int_parity != pkt_parity);
        err_checked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: good/bad parity, FIFO-full stalls,
// reserved address, rst_int_reg and asynchronous reset mid-packet.
module tb_router_reg;

  logic       clock;
  logic       reset;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_packet_valid;
  logic       err;

  int n_checks;
  int n_pass;
  logic [7:0] exp_q[$];

  router_reg #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .rst_int_reg(rst_int_reg), .dout(dout), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid), .err(err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, observed, expected);
  endtask

  task automatic check_dout(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: expected queue empty, dout %h", tag, dout);
    end else begin
      e = exp_q.pop_front();
      check(tag, dout, e);
    end
  endtask

  // driver: apply one cycle of strobes, inputs settle 1 time unit after the edge
  task automatic drive(input logic da, input logic lfd, input logic ld, input logic laf,
                       input logic full, input logic rir, input logic pv,
                       input logic [7:0] d, input logic ff);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = full; rst_int_reg = rir; pkt_valid = pv; data_in = d; fifo_full = ff;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);
  endtask

  task automatic header(input logic [7:0] h);
    drive(1, 0, 0, 0, 0, 0, 1, h, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
  endtask

  initial begin
    logic [7:0] pay [3];
    n_checks = 0;
    n_pass = 0;
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h0F;
    reset = 1'b1;
    detect_add = 0; lfd_state = 0; ld_state = 0; laf_state = 0; full_state = 0;
    rst_int_reg = 0; pkt_valid = 0; data_in = 8'h00; fifo_full = 0;
    @(posedge clock); #1;
    check("reset_dout", dout, 8'h00);
    check("reset_pd", parity_done, 0);
    check("reset_lpv", low_packet_valid, 0);
    check("reset_err", err, 0);
    reset = 1'b0;

    // good packet: 0C A5 3C 0F, parity 9A
    drive(1, 0, 0, 0, 0, 0, 1, 8'h0C, 0);
    check("good_da_dout", dout, 8'h00);
    exp_q.push_back(8'h0C);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    check_dout("good_lfd_dout");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pay[i]);
      drive(0, 0, 1, 0, 0, 0, 1, pay[i], 0);
      check_dout("good_ld_dout");
      check("good_ld_pd", parity_done, 0);
    end
    exp_q.push_back(8'h9A);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h9A, 0);
    check_dout("good_par_dout");
    check("good_pd", parity_done, 1);
    check("good_lpv", low_packet_valid, 1);
    idle();
    check("good_err", err, 0);
    drive(0, 0, 0, 0, 0, 1, 0, 8'h00, 0);
    check("rir_clears_lpv", low_packet_valid, 0);

    // bad parity
    header(8'h0C);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 1, pay[i], 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h00, 0);
    check("bad_pd", parity_done, 1);
    check("bad_err_early", err, 0);
    idle();
    check("bad_err", err, 1);
    idle();
    check("bad_err_hold", err, 1);
    drive(1, 0, 0, 0, 0, 0, 1, 8'h0C, 0);
    check("bad_err_clr", err, 0);
    check("bad_pd_clr", parity_done, 0);

    // FIFO full mid-payload (detect_add already done above)
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'hA5, 0);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h3C, 1);
    check("ff_ld_dout", dout, 8'hA5);
    drive(0, 0, 0, 0, 1, 0, 1, 8'h77, 1);
    check("ff_full1_dout", dout, 8'hA5);
    drive(0, 0, 0, 0, 1, 0, 1, 8'h77, 1);
    check("ff_full2_dout", dout, 8'hA5);
    drive(0, 0, 0, 1, 0, 0, 1, 8'h77, 0);
    check("ff_laf_dout", dout, 8'h3C);
    drive(0, 0, 1, 0, 0, 0, 1, 8'h0F, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h9A, 0);
    check("ff_pd", parity_done, 1);
    idle();
    check("ff_err", err, 0);

    // FIFO full on the parity byte
    header(8'h0C);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 1, pay[i], 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h9A, 1);
    check("fp_pd_stall", parity_done, 0);
    check("fp_lpv", low_packet_valid, 1);
    check("fp_dout_stall", dout, 8'h0F);
    drive(0, 0, 0, 0, 1, 0, 0, 8'h00, 1);
    check("fp_pd_full", parity_done, 0);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    check("fp_laf_pd", parity_done, 1);
    check("fp_laf_dout", dout, 8'h9A);
    drive(0, 0, 0, 1, 0, 0, 0, 8'h00, 0);
    check("fp_laf2_dout", dout, 8'h9A);
    idle();
    check("fp_err", err, 0);

    // reserved address and pkt_valid=0 leave header_reg alone
    header(8'h0F);
    check("resv_hdr", dout, 8'h0C);
    header(8'h11);
    check("hdr_updates", dout, 8'h11);
    drive(1, 0, 0, 0, 0, 0, 0, 8'h22, 0);
    drive(0, 1, 0, 0, 0, 0, 1, 8'h00, 0);
    check("hdr_pv0_keeps", dout, 8'h11);
    // ld set of low_packet_valid beats a simultaneous rst_int_reg
    drive(0, 0, 1, 0, 0, 1, 0, 8'h11, 0);
    check("lpv_set_wins", low_packet_valid, 1);
    idle();
    check("hdr_only_err", err, 0);

    // asynchronous reset with a bad-parity packet in flight
    header(8'h0C);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 1, pay[i], 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h55, 0);
    idle();
    check("pre_rst_err", err, 1);
    #2 reset = 1'b1;
    #1;
    check("async_dout", dout, 8'h00);
    check("async_pd", parity_done, 0);
    check("async_lpv", low_packet_valid, 0);
    check("async_err", err, 0);
    #1 reset = 1'b0;
    idle();

    // clean packet after reset: no residual parity
    header(8'h0C);
    check("post_rst_hdr", dout, 8'h0C);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0, 0, 1, pay[i], 0);
    drive(0, 0, 1, 0, 0, 0, 0, 8'h9A, 0);
    idle();
    check("post_rst_err", err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
